// File: rtl/card_dealer.sv
// card_dealer: deals a 52-card deck without replacement using a Galois LFSR and a linear probe.
// Outputs are registered and hold until the next o_Valid pulse.
module card_dealer #(
    parameter int          SEED_WIDTH = 12,
    parameter logic [15:0] LFSR_INIT  = 16'hACE1
) (
    input  logic                  clk_50M,
    input  logic                  i_Reset,
    input  logic [SEED_WIDTH-1:0] i_Seed,
    input  logic                  i_SeedLoad,
    input  logic                  i_Draw,
    output logic                  o_Busy,
    output logic                  o_Valid,
    output logic [3:0]            o_Rank,
    output logic [1:0]            o_Suit,
    output logic [3:0]            o_Points,
    output logic [5:0]            o_CardsLeft,
    output logic                  o_DeckEmpty
);
    typedef enum logic [2:0] {IDLE, STEP, CHECK, SCAN, DONE} state_t;
    state_t      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [51:0] used_q;
    logic [5:0]  idx_q, idx_d, probe_d, left_q;
    logic [1:0]  suit_q, suit_d;
    logic [3:0]  rank_q, rank_d, pts_q;
    logic        valid_q, empty_q;

    always_comb begin
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        // fold 52..63 onto 40..51 so every LFSR value maps to a card
        idx_d   = (lfsr_d[5:0] >= 6'd52) ? lfsr_d[5:0] - 6'd12 : lfsr_d[5:0];
        probe_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
        suit_d  = (idx_q >= 6'd39) ? 2'd3 : (idx_q >= 6'd26) ? 2'd2 : (idx_q >= 6'd13) ? 2'd1 : 2'd0;
        rank_d  = 4'(idx_q - 6'd13 * {4'd0, suit_d}) + 4'd1;
    end

    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_INIT;
            used_q  <= '0;
            idx_q   <= '0;
            left_q  <= 6'd52;
            valid_q <= 1'b0;
            empty_q <= 1'b0;
            suit_q  <= '0;
            rank_q  <= '0;
            pts_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            empty_q <= (left_q == 6'd0);
            case (state_q)
                IDLE: begin
                    if (i_SeedLoad) begin
                        lfsr_q  <= LFSR_INIT ^ 16'(i_Seed);
                        used_q  <= '0;
                        left_q  <= 6'd52;
                        empty_q <= 1'b0;
                    end else if (i_Draw && left_q != 6'd0) begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    lfsr_q  <= lfsr_d;
                    idx_q   <= idx_d;
                    state_q <= CHECK;
                end
                CHECK, SCAN: begin
                    if (!used_q[idx_q]) begin
                        used_q[idx_q] <= 1'b1;
                        suit_q  <= suit_d;
                        rank_q  <= rank_d;
                        pts_q   <= (rank_d > 4'd10) ? 4'd10 : rank_d;
                        valid_q <= 1'b1;
                        left_q  <= left_q - 6'd1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= probe_d;
                        state_q <= SCAN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Busy      = (state_q != IDLE);
    assign o_Valid     = valid_q;
    assign o_Rank      = rank_q;
    assign o_Suit      = suit_q;
    assign o_Points    = pts_q;
    assign o_CardsLeft = left_q;
    assign o_DeckEmpty = empty_q;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench; stimulus pushes expected cards, a negedge monitor pops on o_Valid.
module tb_card_dealer;
    logic        clk_50M = 1'b0;
    logic        i_Reset = 1'b1;
    logic [11:0] i_Seed = '0;
    logic        i_SeedLoad = 1'b0;
    logic        i_Draw = 1'b0;
    logic        o_Busy, o_Valid, o_DeckEmpty;
    logic [3:0]  o_Rank, o_Points;
    logic [1:0]  o_Suit;
    logic [5:0]  o_CardsLeft;

    card_dealer #(.SEED_WIDTH(12), .LFSR_INIT(16'hACE1)) dut (
        .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Seed(i_Seed), .i_SeedLoad(i_SeedLoad),
        .i_Draw(i_Draw), .o_Busy(o_Busy), .o_Valid(o_Valid), .o_Rank(o_Rank), .o_Suit(o_Suit),
        .o_Points(o_Points), .o_CardsLeft(o_CardsLeft), .o_DeckEmpty(o_DeckEmpty)
    );

    always #10 clk_50M = ~clk_50M;

    int          checks = 0, passes = 0, valid_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left;
    bit          collect = 0;
    bit          seen[52];
    int          seen_cnt = 0, pts_sum = 0;
    int          rank_cnt[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] stp(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic peek(output int id, output int pr);
        logic [15:0] l;
        l = stp(m_lfsr);
        id = int'(l[5:0]);
        if (id >= 52) id -= 12;
        pr = 0;
        while (m_used[id]) begin
            id = (id + 1) % 52;
            pr++;
        end
    endtask

    task automatic model_reset(input logic [15:0] l);
        m_lfsr = l;
        foreach (m_used[i]) m_used[i] = 0;
        m_left = 52;
    endtask

    task automatic push_exp(input bit hc, input logic [1:0] s, input logic [3:0] r,
                            input logic [3:0] p, output int pr);
        int id, rk;
        peek(id, pr);
        m_lfsr = stp(m_lfsr);
        m_used[id] = 1;
        m_left--;
        rk = id % 13 + 1;
        if (hc) exp_q.push_back({s, r, p, 6'(m_left)});
        else exp_q.push_back({2'(id / 13), 4'(rk), 4'((rk > 10) ? 10 : rk), 6'(m_left)});
    endtask

    task automatic tick;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_reset;
        i_Reset = 1; i_Draw = 0; i_SeedLoad = 0;
        tick; tick;
        i_Reset = 0;
        model_reset(16'hACE1);
    endtask

    task automatic seed_load(input logic [11:0] s);
        i_Seed = s; i_SeedLoad = 1;
        tick;
        i_SeedLoad = 0;
        model_reset(16'hACE1 ^ {4'h0, s});
        chk("seed_cards_left", int'(o_CardsLeft), 52);
    endtask

    task automatic draw(input bit hc, input logic [1:0] s, input logic [3:0] r, input logic [3:0] p);
        int pr, n;
        push_exp(hc, s, r, p, pr);
        i_Draw = 1;
        tick;
        i_Draw = 0;
        n = 1;
        while (!o_Valid && n < 200) begin
            tick;
            n++;
        end
        chk("latency", n, 3 + pr);
        tick;
    endtask

    always @(negedge clk_50M) begin
        if (o_Valid) begin
            int id;
            logic [15:0] e;
            valid_cnt++;
            id = int'(o_Suit) * 13 + int'(o_Rank) - 1;
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("card", int'({o_Suit, o_Rank, o_Points, o_CardsLeft}), int'(e));
            end
            if (collect && id >= 0 && id < 52 && o_Rank <= 4'd13) begin
                if (!seen[id]) seen_cnt++;
                seen[id] = 1;
                rank_cnt[o_Rank]++;
                pts_sum += int'(o_Points);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, pr, id;
        bit busy_seen, found;
        foreach (rank_cnt[i]) rank_cnt[i] = 0;

        do_reset;
        chk("reset_cards_left", int'(o_CardsLeft), 52);
        chk("reset_valid", int'(o_Valid), 0);
        chk("reset_busy", int'(o_Busy), 0);
        chk("reset_rank", int'(o_Rank), 0);
        chk("reset_deck_empty", int'(o_DeckEmpty), 0);

        draw(1, 2'd3, 4'd10, 4'd10);
        seed_load(12'h000);
        draw(1, 2'd3, 4'd10, 4'd10);
        seed_load(12'h001);
        draw(1, 2'd3, 4'd10, 4'd10);
        seed_load(12'h011);
        draw(1, 2'd3, 4'd6, 4'd6);

        n0 = valid_cnt;
        i_Seed = 12'h000; i_SeedLoad = 1; i_Draw = 1;
        tick;
        i_SeedLoad = 0; i_Draw = 0;
        model_reset(16'hACE1);
        chk("load_beats_draw_busy", int'(o_Busy), 0);
        chk("load_beats_draw_left", int'(o_CardsLeft), 52);
        repeat (5) tick;
        chk("load_beats_draw_valid", valid_cnt - n0, 0);

        do_reset;
        collect = 1;
        repeat (52) draw(0, 2'd0, 4'd0, 4'd0);
        collect = 0;
        chk("distinct_cards", seen_cnt, 52);
        for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), rank_cnt[r], 4);
        chk("points_sum", pts_sum, 340);
        chk("empty_cards_left", int'(o_CardsLeft), 0);
        chk("deck_empty", int'(o_DeckEmpty), 1);
        n0 = valid_cnt;
        busy_seen = 0;
        i_Draw = 1;
        repeat (6) begin
            tick;
            if (o_Busy) busy_seen = 1;
        end
        i_Draw = 0;
        chk("empty_draw_busy", int'(busy_seen), 0);
        chk("empty_draw_valid", valid_cnt - n0, 0);

        do_reset;
        draw(0, 2'd0, 4'd0, 4'd0);
        push_exp(0, 2'd0, 4'd0, 4'd0, pr);
        n0 = valid_cnt;
        i_Draw = 1;
        tick;
        i_Seed = 12'h011; i_SeedLoad = 1;
        tick;
        i_SeedLoad = 0; i_Draw = 0;
        repeat (60) tick;
        chk("busy_ignored_valids", valid_cnt - n0, 1);
        chk("busy_ignored_left", int'(o_CardsLeft), 50);
        repeat (8) draw(0, 2'd0, 4'd0, 4'd0);
        chk("ten_draws_left", int'(o_CardsLeft), 42);
        seed_load(12'h000);

        do_reset;
        found = 0;
        while (m_left > 0 && !found) begin
            peek(id, pr);
            if (m_left <= 12 && pr >= 1) found = 1;
            else draw(0, 2'd0, 4'd0, 4'd0);
        end
        chk("scan_candidate_found", int'(found), 1);
        if (found) begin
            n0 = valid_cnt;
            i_Draw = 1;
            tick;
            i_Draw = 0;
            tick; tick;
            chk("busy_in_scan", int'(o_Busy), 1);
            i_Reset = 1;
            tick;
            i_Reset = 0;
            model_reset(16'hACE1);
            chk("abort_busy", int'(o_Busy), 0);
            chk("abort_cards_left", int'(o_CardsLeft), 52);
            chk("abort_valid", int'(o_Valid), 0);
            repeat (5) tick;
            chk("abort_no_valid", valid_cnt - n0, 0);
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
